bp_me_wb_arbiter: RTL and testbench

BP_ME_WB_ARBITER -- requirements
Module: bp_me_wb_arbiter

---
 rtl/bp_me_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bp_me_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_wb_arbiter.sv
// bp_me_wb_arbiter
//   Two-master to one-slave Wishbone arbiter. Master 0 is the I$ WB master,
//   master 1 is the D$ WB master. A grant is held for as long as the granted
//   master keeps cyc high. A simultaneous request from IDLE goes to the master
//   not granted most recently. Request fields are routed combinationally; there
//   is no data buffering, so slave latency reaches the master unchanged.
//
//   Optional watchdog, enabled with `define BP_ME_WB_ARB_TIMEOUT_EN:
//   if the slave leaves a strobed request without ack/err for timeout_p cycles,
//   the granted master gets a one-cycle err. During that cycle the slave-side
//   stb is masked.
//
// Ports
//   clk_i, reset_i             clock, async active-high reset
//   m0_*_i / m0_*_o            master 0 request / response (ack, err, dat)
//   m1_*_i / m1_*_o            master 1 request / response
//   s_*_o / s_*_i              shared slave request / response
//
// state    | meaning
// ---------+----------------------------------------------------
// e_idle   | no owner; slave cyc/stb and all master ack/err low
// e_grant0 | master 0 owns the slave until m0_cyc_i is seen low
// e_grant1 | master 1 owns the slave until m1_cyc_i is seen low

module bp_me_wb_arbiter #(
  parameter int adr_width_p  = 37,
  parameter int data_width_p = 64,
  parameter int timeout_p    = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [adr_width_p-1:0]    m0_adr_i,
  input  logic [data_width_p-1:0]   m0_dat_i,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic [data_width_p/8-1:0] m0_sel_i,
  input  logic                      m0_we_i,
  input  logic [2:0]                m0_cti_i,
  input  logic [1:0]                m0_bte_i,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  output logic [data_width_p-1:0]   m0_dat_o,

  input  logic [adr_width_p-1:0]    m1_adr_i,
  input  logic [data_width_p-1:0]   m1_dat_i,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic [data_width_p/8-1:0] m1_sel_i,
  input  logic                      m1_we_i,
  input  logic [2:0]                m1_cti_i,
  input  logic [1:0]                m1_bte_i,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic [data_width_p-1:0]   m1_dat_o,

  output logic [adr_width_p-1:0]    s_adr_o,
  output logic [data_width_p-1:0]   s_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [data_width_p/8-1:0] s_sel_o,
  output logic                      s_we_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic [data_width_p-1:0]   s_dat_i
);

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_grant0 = 2'd1,
    e_grant1 = 2'd2
  } state_e;

  state_e state_r;
  logic   last_grant_r;   // 0: master 0 granted most recently, 1: master 1
  logic   granted;
  logic   gnt_stb;
  logic   wd_fire;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      last_grant_r <= 1'b1;   // master 0 wins the first tie
    end else begin
      case (state_r)
        e_idle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_grant_r)) begin
            state_r      <= e_grant0;
            last_grant_r <= 1'b0;
          end else if (m1_cyc_i) begin
            state_r      <= e_grant1;
            last_grant_r <= 1'b1;
          end
        end
        e_grant0: if (!m0_cyc_i) state_r <= e_idle;
        e_grant1: if (!m1_cyc_i) state_r <= e_idle;
        default:  state_r <= e_idle;
      endcase
    end
  end

  assign granted = (state_r == e_grant0) || (state_r == e_grant1);
  assign gnt_stb = ((state_r == e_grant0) && m0_stb_i) ||
                   ((state_r == e_grant1) && m1_stb_i);

`ifdef BP_ME_WB_ARB_TIMEOUT_EN
  localparam int wd_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [wd_width_lp-1:0] wd_last_lp = wd_width_lp'(timeout_p - 1);

  logic [wd_width_lp-1:0] wd_cnt_r;

  assign wd_fire = gnt_stb && !s_ack_i && !s_err_i && (wd_cnt_r == wd_last_lp);

  // Also cleared on its own fire so a master that keeps stb up restarts the wait.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      wd_cnt_r <= '0;
    else if (!granted || s_ack_i || s_err_i || wd_fire)
      wd_cnt_r <= '0;
    else if (gnt_stb)
      wd_cnt_r <= wd_cnt_r + 1'b1;
  end
`else
  assign wd_fire = 1'b0;

  // Keeps timeout_p referenced when the watchdog is compiled out.
  if (timeout_p < 1) begin : g_timeout_p_unused
  end
`endif

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cti_o  = 3'b000;
    s_bte_o  = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_r)
      e_grant0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !wd_fire;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || wd_fire;
      end
      e_grant1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !wd_fire;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || wd_fire;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
module tb_bp_me_wb_arbiter;

  localparam int AW = 37;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;

  logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
  logic [DW-1:0] m0_dat, m1_dat, s_dat_o, s_dat_i, m0_dat_o, m1_dat_o;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [SW-1:0] m0_sel, m1_sel, s_sel_o;
  logic [2:0]    m0_cti, m1_cti, s_cti_o;
  logic [1:0]    m0_bte, m1_bte, s_bte_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack, s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_me_wb_arbiter #(.adr_width_p(AW), .data_width_p(DW), .timeout_p(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat_i)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave-side request bundle as the bench expects it for a given owner.
  function automatic logic [127:0] route_of(input int g);
    if (g == 1) return {13'b0, m0_adr, m0_dat, m0_sel, m0_we, m0_cti, m0_bte};
    return {13'b0, m1_adr, m1_dat, m1_sel, m1_we, m1_cti, m1_bte};
  endfunction

  function automatic logic [127:0] route_act();
    return {13'b0, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o};
  endfunction

  typedef struct {
    logic c0, s0, c1, s1, ack, err;
    int   g;                                  // 0 none, 1 master 0, 2 master 1
    logic e_cyc, e_stb, e_a0, e_e0, e_a1, e_e1;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int beats, m1_seen, n, nerr, first_k;
    logic [2:0] last_cti;
    logic pend0, pend1, drop0, drop1;
    int owner;

    vecs[0]  = '{0,0,0,0,0,0, 0, 0,0,0,0,0,0};
    vecs[1]  = '{1,1,1,1,1,0, 0, 0,0,0,0,0,0};
    vecs[2]  = '{1,1,1,1,0,0, 1, 1,1,0,0,0,0};
    vecs[3]  = '{1,1,1,1,1,0, 1, 1,1,1,0,0,0};
    vecs[4]  = '{1,0,1,1,0,0, 1, 1,0,0,0,0,0};
    vecs[5]  = '{1,1,1,1,0,1, 1, 1,1,0,1,0,0};
    vecs[6]  = '{0,0,1,1,0,0, 1, 0,0,0,0,0,0};
    vecs[7]  = '{0,0,1,1,0,0, 0, 0,0,0,0,0,0};
    vecs[8]  = '{0,0,1,1,1,0, 2, 1,1,0,0,1,0};
    vecs[9]  = '{1,1,0,0,0,0, 2, 0,0,0,0,0,0};
    vecs[10] = '{1,1,0,0,0,0, 0, 0,0,0,0,0,0};
    vecs[11] = '{1,1,1,1,1,0, 1, 1,1,1,0,0,0};
    vecs[12] = '{0,0,1,1,0,0, 1, 0,0,0,0,0,0};
    vecs[13] = '{1,1,1,1,0,0, 0, 0,0,0,0,0,0};
    vecs[14] = '{1,1,1,1,1,0, 2, 1,1,0,0,1,0};
    vecs[15] = '{1,1,1,1,0,1, 2, 1,1,0,0,0,1};
    vecs[16] = '{1,1,0,0,0,0, 2, 0,0,0,0,0,0};
    vecs[17] = '{1,1,0,0,0,0, 0, 0,0,0,0,0,0};
    vecs[18] = '{1,1,0,0,0,0, 1, 1,1,0,0,0,0};
    vecs[19] = '{0,0,0,0,0,0, 1, 0,0,0,0,0,0};
    vecs[20] = '{0,0,0,0,0,0, 0, 0,0,0,0,0,0};

    m0_adr = 37'h100;  m0_dat = 64'h1111_2222_3333_4444; m0_sel = 8'h0F; m0_we = 1'b0;
    m0_cti = 3'b000;   m0_bte = 2'b00;
    m1_adr = 37'h1000; m1_dat = 64'h5555_6666_7777_8888; m1_sel = 8'hFF; m1_we = 1'b1;
    m1_cti = 3'b111;   m1_bte = 2'b01;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_dat_i = 64'h0;

    @(negedge clk);
    #1;
    chk("reset_s_cyc", s_cyc_o, 1'b0);
    chk("reset_m_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
    @(negedge clk);
    reset = 1'b0;

    // Directed per-cycle vectors
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      m0_cyc = vecs[i].c0; m0_stb = vecs[i].s0;
      m1_cyc = vecs[i].c1; m1_stb = vecs[i].s1;
      s_ack = vecs[i].ack; s_err = vecs[i].err;
      s_dat_i = 64'hA5A5_0000_0000_0000 + 64'(i);
      #1;
      chk($sformatf("v%0d_cyc_stb", i), {s_cyc_o, s_stb_o}, {vecs[i].e_cyc, vecs[i].e_stb});
      chk($sformatf("v%0d_resp", i), {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o},
          {vecs[i].e_a0, vecs[i].e_e0, vecs[i].e_a1, vecs[i].e_e1});
      chk($sformatf("v%0d_rdata", i), {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      if (vecs[i].g != 0)
        chk($sformatf("v%0d_route", i), route_act(), route_of(vecs[i].g));
    end
    s_ack = 0; s_err = 0;

    // m0 4-beat burst with m1 requesting throughout
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1;
    beats = 0; m1_seen = 0; last_cti = 3'b000;
    for (int i = 0; i < 20 && beats < 4; i++) begin
      @(negedge clk);
      m0_cti = (beats == 3) ? 3'b111 : 3'b010;
      s_ack = i[0];
      #1;
      if (m1_ack_o || m1_err_o) m1_seen++;
      if (m0_ack_o) begin
        beats++;
        last_cti = s_cti_o;
      end
    end
    chk("burst_beats", beats, 4);
    chk("burst_m1_stalled", m1_seen, 0);
    chk("burst_last_cti", last_cti, 3'b111);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; m0_cti = 3'b000; s_ack = 0;
    #1;
    chk("burst_drop_cyc", s_cyc_o, 1'b0);
    @(negedge clk);
    #1;
    chk("burst_idle_gap", {s_cyc_o, m1_ack_o}, 2'b00);
    @(negedge clk);
    #1;
    chk("burst_m1_granted", {s_cyc_o, s_adr_o}, {1'b1, m1_adr});
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);

    // Alternating simultaneous requests, 8 transactions, expect 0,1,0,1,...
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    n = 0; pend0 = 0; pend1 = 0; drop0 = 0; drop1 = 0;
    #1;
    for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
      @(negedge clk);
      s_ack = 0;
      if (pend0) begin m0_cyc = 1; m0_stb = 1; pend0 = 0; end
      if (pend1) begin m1_cyc = 1; m1_stb = 1; pend1 = 0; end
      if (drop0) begin m0_cyc = 0; m0_stb = 0; drop0 = 0; pend0 = 1; end
      if (drop1) begin m1_cyc = 0; m1_stb = 0; drop1 = 0; pend1 = 1; end
      #1;
      if (s_cyc_o && s_stb_o) begin
        owner = (s_adr_o == m0_adr) ? 0 : 1;
        chk($sformatf("alt%0d_owner", n), owner, n % 2);
        s_ack = 1;
        #1;
        chk($sformatf("alt%0d_ack", n), {m0_ack_o, m1_ack_o}, (owner == 0) ? 2'b10 : 2'b01);
        if (owner == 0) drop0 = 1; else drop1 = 1;
        n++;
      end
    end
    chk("alt_count", n, 8);
    @(negedge clk);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of an m1 write
    m1_adr = 37'h1000; m1_sel = 8'hFF; m1_we = 1'b1; m1_cti = 3'b000;
    m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    #1;
    chk("rst_m1_granted", {s_cyc_o, s_we_o, s_sel_o, s_adr_o}, {1'b1, 1'b1, 8'hFF, 37'h1000});
    @(negedge clk);
    s_ack = 1;
    reset = 1;
    #1;
    chk("rst_abort_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("rst_abort_no_resp", {m1_ack_o, m1_err_o}, 2'b00);
    @(negedge clk);
    #1;
    chk("rst_held_idle", {s_cyc_o, m1_ack_o}, 2'b00);
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    reset = 0;
    @(negedge clk);
    #1;
    chk("rst_after_idle", {s_cyc_o, m1_ack_o, m1_err_o}, 3'b000);

    // Make master 0 the most recent grant, then reset: master 0 must still win a tie
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    #1;
    chk("rst_tie_m0_wins", {s_cyc_o, s_adr_o}, {1'b1, m0_adr});
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Slave never answers an m0 request
    m0_cyc = 1; m0_stb = 1; m0_cti = 3'b000;
    nerr = 0; first_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (m0_err_o) begin
        nerr++;
        if (first_k < 0) begin
          first_k = k;
          chk("wd_stb_masked", s_stb_o, 1'b0);
          m0_cyc = 0; m0_stb = 0;
        end
      end
    end
`ifdef BP_ME_WB_ARB_TIMEOUT_EN
    chk("wd_err_cycle", first_k, 16);
    chk("wd_err_once", nerr, 1);
`else
    chk("hang_no_err", nerr, 0);
    chk("hang_still_cyc", {s_cyc_o, s_stb_o}, 2'b11);
`endif
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
